cla32_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one `cla32btadder` instance between N_REQ requesters. Each requester presents two 32-bit operands and a carry-in with a valid/ready handshake. The block grants at most one requester per cycle and registers the sum, carry-out and requester ID into a single output slot with its own valid/ready handshake. It sits between the operand-producing units and the result consumer, so they no longer each need a private adder.

---
 rtl/cla32_rr_arbiter_if.sv | 24 ++
 rtl/cla32_rr_arbiter.sv | 84 ++++++++
 tb/tb_cla32_rr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla32_rr_arbiter_if.sv
// cla32_rr_arbiter_if: requester and result handshake bundle for the shared-adder arbiter.
interface cla32_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_cin;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic                res_valid;
  logic                res_ready;
  logic [31:0]         res_sum;
  logic                res_cout;
  logic [ID_W-1:0]     res_id;
  modport master (
    output req_valid, req_a, req_b, req_cin, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_id
  );
  modport slave (
    input  req_valid, req_a, req_b, req_cin, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_id
  );
endinterface

// File: rtl/cla32_rr_arbiter.sv
// cla32_rr_arbiter: round-robin sharing of one 32-bit block carry-lookahead adder with a registered result slot.
module cla32btadder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g, p, c;
  logic [8:0]  bc;
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    bc = '0;
    bc[0] = cin;
    // block carries come from group generate/propagate, bits inside a block ripple from their block carry
    for (int j = 0; j < 8; j++) begin
      c[4*j] = bc[j];
      for (int i = 1; i < 4; i++) c[4*j+i] = g[4*j+i-1] | (p[4*j+i-1] & c[4*j+i-1]);
      bc[j+1] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
              | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
              | (&p[4*j+:4] & bc[j]);
    end
    sum  = p ^ c;
    cout = bc[8];
  end
endmodule

module cla32_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input logic clk,
  input logic rst,
  cla32_rr_arbiter_if.slave bus
);
  logic [ID_W-1:0] ptr, gid, sel, nxt;
  logic [ID_W:0]   s;
  logic            found, slot_free, xfer, cout;
  logic [31:0]     sum;
  always_comb begin
    gid   = '0;
    found = 1'b0;
    s     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = {1'b0, ptr} + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(N_REQ)) s = s - (ID_W+1)'(N_REQ);
      if (!found && bus.req_valid[s[ID_W-1:0]]) begin
        found = 1'b1;
        gid   = s[ID_W-1:0];
      end
    end
  end
  assign slot_free     = !bus.res_valid | bus.res_ready;
  assign xfer          = found & slot_free;
  assign bus.req_ready = (xfer && !rst) ? N_REQ'(1) << gid : '0;
  assign sel           = found ? gid : ptr;
  assign nxt           = (gid == ID_W'(N_REQ-1)) ? '0 : gid + ID_W'(1);
  cla32btadder adder (
    .a   (bus.req_a[32*sel +: 32]),
    .b   (bus.req_b[32*sel +: 32]),
    .cin (bus.req_cin[sel]),
    .sum (sum),
    .cout(cout)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_cout  <= 1'b0;
      bus.res_id    <= '0;
    end else if (xfer) begin
      ptr          <= nxt;
      bus.res_valid <= 1'b1;
      bus.res_sum   <= sum;
      bus.res_cout  <= cout;
      bus.res_id    <= gid;
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cla32_rr_arbiter.sv
// tb_cla32_rr_arbiter: randomized and directed checks of the arbiter against a queue-free rotating-priority model.
module tb_cla32_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  cla32_rr_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();
  cla32_rr_arbiter #(.N_REQ(4), .ID_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_sum = '0;
  logic        m_cout = 1'b0;
  int          m_id = 0;
  int          last_g = -1;

  function automatic int pick(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic int exp_gid();
    if (rst || (m_valid && !bus.res_ready)) return -1;
    return pick(bus.req_valid, m_ptr);
  endfunction

  function automatic logic [3:0] exp_rdy();
    int g = exp_gid();
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_id = 0;
  endtask

  task automatic tick();
    int g;
    logic [32:0] s;
    logic rr;
    g  = exp_gid();
    rr = bus.res_ready;
    s  = '0;
    if (g >= 0) s = {1'b0, bus.req_a[32*g +: 32]} + {1'b0, bus.req_b[32*g +: 32]} + 33'(bus.req_cin[g]);
    @(posedge clk);
    last_g = g;
    if (g >= 0) begin
      m_sum = s[31:0]; m_cout = s[32]; m_id = g; m_valid = 1'b1; m_ptr = (g + 1) % 4;
    end else if (m_valid && rr) m_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_req(int i, logic v, logic [31:0] a, logic [31:0] b, logic c);
    bus.req_valid[i]     = v;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_cin[i]       = c;
  endtask

  task automatic test_reset();
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold ready=%b valid=%b want 0000/0", bus.req_ready, bus.res_valid);
    end
    bus.req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b1, 32'd5, 32'd6, 1'b1);
    bus.res_ready = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_first_grant ready=%b want 0001", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 32'd12) begin
      errors++; $display("FAIL reset_prefill valid=%b sum=%h want 1/0000000c", bus.res_valid, bus.res_sum);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_sum !== 32'd0 || bus.res_cout !== 1'b0 || bus.res_id !== 2'd0 || bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_async valid=%b sum=%h cout=%b id=%0d ready=%b want all 0",
        bus.res_valid, bus.res_sum, bus.res_cout, bus.res_id, bus.req_ready);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_release_grant ready=%b want 0001", bus.req_ready);
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    bus.res_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready ready=%b want 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 32'h0 || bus.res_cout !== 1'b1 || bus.res_id !== 2'd0) begin
      errors++; $display("FAIL single_result valid=%b sum=%h cout=%b id=%0d want 1/00000000/1/0",
        bus.res_valid, bus.res_sum, bus.res_cout, bus.res_id);
    end
    tick();
  endtask

  task automatic test_contention();
    int seen2 = 0;
    rst = 1'b1;
    #1 model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, $urandom, $urandom, 1'($urandom));
    set_req(2, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    bus.res_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'(1 << (n % 4))) begin
        errors++; $display("FAIL contention_grant cycle=%0d ready=%b want %b", n, bus.req_ready, 4'(1 << (n % 4)));
      end
      tick();
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(n % 4) || bus.res_sum !== m_sum || bus.res_cout !== m_cout) begin
        errors++; $display("FAIL contention_result cycle=%0d id=%0d sum=%h cout=%b want %0d/%h/%b",
          n, bus.res_id, bus.res_sum, bus.res_cout, n % 4, m_sum, m_cout);
      end
      if (n % 4 == 2) begin
        seen2++;
        checks++;
        if (bus.res_sum !== 32'h8000_0001 || bus.res_cout !== 1'b0) begin
          errors++; $display("FAIL contention_req2 sum=%h cout=%b want 80000001/0", bus.res_sum, bus.res_cout);
        end
      end
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] hs;
    logic hc;
    logic [1:0] hi;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, $urandom, $urandom, 1'($urandom));
    bus.res_ready = 1'b1;
    tick();
    hs = bus.res_sum; hc = bus.res_cout; hi = bus.res_id;
    bus.res_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_ready cycle=%0d ready=%b want 0000", n, bus.req_ready);
      end
      tick();
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_sum !== hs || bus.res_cout !== hc || bus.res_id !== hi) begin
        errors++; $display("FAIL bp_hold cycle=%0d valid=%b sum=%h id=%0d want 1/%h/%0d", n, bus.res_valid, bus.res_sum, bus.res_id, hs, hi);
      end
    end
    bus.res_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== exp_rdy() || bus.req_ready === 4'b0000) begin
      errors++; $display("FAIL bp_release_grant ready=%b want %b", bus.req_ready, exp_rdy());
    end
    tick();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(m_id) || bus.res_sum !== m_sum || bus.res_cout !== m_cout) begin
      errors++; $display("FAIL bp_no_bubble valid=%b id=%0d sum=%h want 1/%0d/%h", bus.res_valid, bus.res_id, bus.res_sum, m_id, m_sum);
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    set_req(0, 1'b1, 32'd1, 32'd2, 1'b0);
    bus.res_ready = 1'b1;
    tick();
    set_req(0, 1'b1, 32'd10, 32'd20, 1'b0);
    set_req(3, 1'b1, 32'd30, 32'd40, 1'b1);
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++; $display("FAIL wrap_first ready=%b want 1000", bus.req_ready);
    end
    tick();
    bus.req_valid[3] = 1'b0;
    checks++;
    if (bus.res_id !== 2'd3 || bus.res_sum !== 32'd71) begin
      errors++; $display("FAIL wrap_id3 id=%0d sum=%h want 3/00000047", bus.res_id, bus.res_sum);
    end
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL wrap_second ready=%b want 0001", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.res_id !== 2'd0 || bus.res_sum !== 32'd30) begin
      errors++; $display("FAIL wrap_id0 id=%0d sum=%h want 0/0000001e", bus.res_id, bus.res_sum);
    end
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL wrap_ptr ready=%b want 0010", bus.req_ready);
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_idle_drain();
    int p;
    set_req(2, 1'b1, 32'd7, 32'd8, 1'b0);
    bus.res_ready = 1'b1;
    tick();
    bus.req_valid = 4'b0000;
    p = m_ptr;
    tick();
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL idle_drain valid=%b want 0", bus.res_valid);
    end
    repeat (3) tick();
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'(1 << p)) begin
      errors++; $display("FAIL idle_ptr ready=%b want %b", bus.req_ready, 4'(1 << p));
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    bus.req_valid = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        if (!bus.req_valid[i] || last_g == i)
          set_req(i, 1'($urandom_range(0, 2) != 0), $urandom, $urandom, 1'($urandom));
      bus.res_ready = 1'($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (bus.req_ready !== exp_rdy()) begin
        errors++; $display("FAIL rand_ready cycle=%0d ready=%b want %b", n, bus.req_ready, exp_rdy());
      end
      tick();
      checks++;
      if (bus.res_valid !== m_valid || (m_valid && (bus.res_sum !== m_sum || bus.res_cout !== m_cout || bus.res_id !== 2'(m_id)))) begin
        errors++; $display("FAIL rand_result cycle=%0d valid=%b sum=%h cout=%b id=%0d want %b/%h/%b/%0d",
          n, bus.res_valid, bus.res_sum, bus.res_cout, bus.res_id, m_valid, m_sum, m_cout, m_id);
      end
    end
  endtask

  initial begin
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_idle_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
